// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction queue between 2-wide fetch and decode.
// Ports: clk/reset, flush, in_* from fetch, out_* to decode, count/empty/full status.
module fetch_queue #(
   parameter int FETCH_W = 2,
   parameter int XLEN    = 32,
   parameter int DEPTH   = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic [FETCH_W-1:0]             in_valid,
   input  logic [FETCH_W-1:0][XLEN-1:0]   in_pc,
   input  logic [FETCH_W-1:0][XLEN-1:0]   in_instr,
   output logic                           in_ready,
   output logic [FETCH_W-1:0]             out_valid,
   output logic [FETCH_W-1:0][XLEN-1:0]   out_pc,
   output logic [FETCH_W-1:0][XLEN-1:0]   out_instr,
   input  logic                           out_ready,
   output logic [$clog2(DEPTH):0]         count,
   output logic                           empty,
   output logic                           full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0] mem_pc    [DEPTH];
   logic [XLEN-1:0] mem_instr [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] n_in;
   logic [CW-1:0] n_out;
   logic [CW-1:0] free;
   logic [PW-1:0] wr_idx [FETCH_W];
   logic [PW-1:0] rd_idx [FETCH_W];
   logic          enq;
   logic          deq;

   assign free     = CW'(DEPTH) - count;
   assign in_ready = free >= CW'(FETCH_W);
   assign empty    = count == '0;
   assign full     = count == CW'(DEPTH);
   assign enq      = in_ready && (|in_valid) && !flush;
   assign deq      = out_ready && !flush;

   // Compaction: each valid lane lands after the valid lanes below it.
   always_comb begin
      n_in = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         wr_idx[i] = tail + n_in[PW-1:0];
         n_in      = n_in + {{(CW-1){1'b0}}, in_valid[i]};
      end
   end

   always_comb begin
      n_out = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         rd_idx[i]    = head + PW'(i);
         out_valid[i] = count > CW'(i);
         out_pc[i]    = out_valid[i] ? mem_pc[rd_idx[i]]    : '0;
         out_instr[i] = out_valid[i] ? mem_instr[rd_idx[i]] : '0;
         n_out        = n_out + {{(CW-1){1'b0}}, out_valid[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         for (int i = 0; i < FETCH_W; i++) begin
            if (in_valid[i]) begin
               mem_pc[wr_idx[i]]    <= in_pc[i];
               mem_instr[wr_idx[i]] <= in_instr[i];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) tail <= tail + n_in[PW-1:0];
         if (deq) head <= head + n_out[PW-1:0];
         count <= count + (enq ? n_in : '0) - (deq ? n_out : '0);
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue.
// Stimulus pushes accepted entries into a model FIFO; a negedge monitor compares and pops.
module tb_fetch_queue;

   localparam int FW = 2;
   localparam int XW = 32;
   localparam int D  = 8;

   typedef struct packed {
      logic [XW-1:0] pc;
      logic [XW-1:0] instr;
   } ent_t;

   logic                  clk = 0;
   logic                  reset;
   logic                  flush;
   logic [FW-1:0]         in_valid;
   logic [FW-1:0][XW-1:0] in_pc;
   logic [FW-1:0][XW-1:0] in_instr;
   logic                  in_ready;
   logic [FW-1:0]         out_valid;
   logic [FW-1:0][XW-1:0] out_pc;
   logic [FW-1:0][XW-1:0] out_instr;
   logic                  out_ready;
   logic [$clog2(D):0]    count;
   logic                  empty;
   logic                  full;

   fetch_queue #(.FETCH_W(FW), .XLEN(XW), .DEPTH(D)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
      .in_ready(in_ready),
      .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
      .out_ready(out_ready),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   ent_t exp_q[$];
   int   n_pushed = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // The reference model: a FIFO of entries, accepting a bundle only
   // when at least FW slots are free at the start of the cycle.
   task automatic drive(input logic [FW-1:0] v,
                        input logic [XW-1:0] p0, input logic [XW-1:0] p1,
                        input logic [XW-1:0] i0, input logic [XW-1:0] i1,
                        input logic ordy, input logic fl);
      @(posedge clk);
      #1;
      in_valid    = v;
      in_pc[0]    = p0;
      in_pc[1]    = p1;
      in_instr[0] = i0;
      in_instr[1] = i1;
      out_ready   = ordy;
      flush       = fl;
      n_pushed    = 0;
      if (!reset && !fl && v != 0 && (D - exp_q.size()) >= FW) begin
         if (v[0]) begin
            exp_q.push_back('{pc: p0, instr: i0});
            n_pushed++;
         end
         if (v[1]) begin
            exp_q.push_back('{pc: p1, instr: i1});
            n_pushed++;
         end
      end
   endtask

   task automatic idle(input logic ordy, input int n);
      for (int k = 0; k < n; k++) drive(2'b00, 0, 0, 0, 0, ordy, 1'b0);
   endtask

   task automatic bundle(input logic [FW-1:0] v, input logic [XW-1:0] p0,
                         input logic ordy);
      drive(v, p0, p0 + 4, $urandom, $urandom, ordy, 1'b0);
   endtask

   // Monitor: entries visible to decode exclude this cycle's pushes.
   always @(negedge clk) begin
      int vis;
      int nd;
      vis = exp_q.size() - n_pushed;
      chk("count", count, vis);
      chk("empty", empty, vis == 0);
      chk("full", full, vis == D);
      chk("in_ready", in_ready, (D - vis) >= FW);
      for (int i = 0; i < FW; i++) begin
         chk($sformatf("out_valid[%0d]", i), out_valid[i], vis > i);
         if (vis > i) begin
            chk($sformatf("out_pc[%0d]", i), out_pc[i], exp_q[i].pc);
            chk($sformatf("out_instr[%0d]", i), out_instr[i], exp_q[i].instr);
         end else begin
            chk($sformatf("out_pc_zero[%0d]", i), out_pc[i], 0);
            chk($sformatf("out_instr_zero[%0d]", i), out_instr[i], 0);
         end
      end
      if (flush) begin
         exp_q.delete();
      end else if (out_ready) begin
         nd = (vis < FW) ? vis : FW;
         for (int i = 0; i < nd; i++) void'(exp_q.pop_front());
      end
   end

   initial begin
      logic [XW-1:0] pc;
      logic [FW-1:0] v;
      reset     = 1;
      flush     = 0;
      in_valid  = 0;
      in_pc     = '0;
      in_instr  = '0;
      out_ready = 0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_in_ready", in_ready, 1);
      #11 reset = 0;

      drive(2'b11, 32'h0, 32'h4, 32'h2022_1800, 32'h2085_0064, 1'b0, 1'b0);
      idle(1'b0, 1);
      chk("single_pc1", out_pc[1], 32'h4);
      idle(1'b1, 2);

      for (int b = 0; b < 5; b++) bundle(2'b11, 32'(b * 8), 1'b0);
      idle(1'b0, 1);
      chk("fill_full", full, 1);
      idle(1'b1, 6);

      drive(2'b10, 0, 32'h104, 0, 32'h1111, 1'b0, 1'b0);
      idle(1'b0, 1);
      chk("compact_valid", out_valid, 2'b01);
      drive(2'b11, 32'h108, 32'h10C, 32'h2222, 32'h3333, 1'b0, 1'b0);
      idle(1'b1, 3);

      drive(2'b00, 0, 0, 0, 0, 1'b0, 1'b1);
      bundle(2'b01, 32'h200, 1'b0);
      bundle(2'b11, 32'h210, 1'b1);
      bundle(2'b11, 32'h220, 1'b1);
      bundle(2'b11, 32'h230, 1'b1);
      for (int k = 0; k < 6; k++) bundle(2'b11, 32'h300 + 32'(k * 8), 1'b1);
      idle(1'b1, 2);

      bundle(2'b11, 32'h400, 1'b0);
      bundle(2'b11, 32'h408, 1'b0);
      bundle(2'b01, 32'h410, 1'b0);
      drive(2'b11, 32'h500, 32'h504, 1, 2, 1'b1, 1'b1);
      idle(1'b1, 1);
      chk("flush_empty", empty, 1);
      chk("flush_in_ready", in_ready, 1);
      idle(1'b1, 1);

      bundle(2'b11, 32'h600, 1'b0);
      bundle(2'b11, 32'h608, 1'b0);
      bundle(2'b11, 32'h610, 1'b0);
      idle(1'b0, 1);
      #3 reset = 1;
      #1;
      chk("arst_count", count, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_pc", out_pc, 0);
      chk("arst_in_ready", in_ready, 1);
      exp_q.delete();
      n_pushed = 0;
      @(negedge clk);
      #2 reset = 0;

      pc = 32'h1000;
      for (int k = 0; k < 400; k++) begin
         v = FW'($urandom_range(0, 3));
         drive(v, pc, pc + 4, $urandom, $urandom,
               $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);
         pc = pc + 8;
      end
      idle(1'b1, 6);
      chk("final_empty", empty, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling instruction queue between the 2-wide fetch stage and the decode stage of the superscalar LEGv8 frontend. It absorbs fetch bundles while decode is back-pressured, presents the oldest instructions in program order to decode, and discards all contents on a pipeline redirect. Fetch uses `in_ready` as its stall input. Decode's `decode_ready` drives `out_ready`.

## Interface
- `FETCH_W`, 2: lanes per bundle on both input and output sides.
- `XLEN`, 32: PC and instruction width.
- `DEPTH`, 8: entry count. Must be a power of two and ≥ 2·FETCH_W.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  redirect/mispredict; discards all entries.
- `in_valid`  in  [FETCH_W-1:0]  per-lane valid from fetch.
- `in_pc`  in  [FETCH_W-1:0][XLEN-1:0]  per-lane PC.
- `in_instr`  in  [FETCH_W-1:0][XLEN-1:0]  per-lane instruction word.
- `in_ready`  out  1  queue can accept a full bundle this cycle.
- `out_valid`  out  [FETCH_W-1:0]  per-lane valid to decode; lane 0 is the oldest.
- `out_pc`  out  [FETCH_W-1:0][XLEN-1:0]  per-lane PC.
- `out_instr`  out  [FETCH_W-1:0][XLEN-1:0]  per-lane instruction word.
- `out_ready`  in  1  decode consumes every presented valid lane.
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.

## Operation
- **Storage:** circular buffer of {pc, instr}.
  - `head` and `tail` pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is tracked separately.
- **in_ready:** `in_ready = (DEPTH - count) >= FETCH_W`.
  - Computed from the current count only. A same-cycle dequeue does not raise it.
- **Enqueue:** occurs when `in_ready && |in_valid && !flush`.
  - Valid lanes are written in ascending lane order at tail, tail+1, …, and invalid lanes are skipped (compaction).
  - Example: `in_valid=2'b10` writes lane 1 at tail.
  - tail advances by popcount(in_valid).
  - If `in_ready=0`, input is ignored. Fetch is responsible for holding the bundle.
- **Output:** `out_valid[i] = (count > i)`.
  - `out_pc[i]` and `out_instr[i]` come from entry (head+i) mod DEPTH.
  - Invalid lanes drive all zeros.
- **Dequeue:** occurs when `out_ready && !flush`.
  - head advances by popcount(out_valid). Consumption is all-or-nothing; there is no partial consumption.
- **Simultaneous enqueue and dequeue:** count_next = count + n_enq − n_deq.
- **Flush:**
  - At the next edge, head, tail and count go to 0.
  - Any same-cycle enqueue and dequeue are dropped.
  - Flush has priority over everything except reset.
- **Reset (asynchronous):**
  - head=tail=count=0.
  - Outputs: out_valid=0, out_pc/out_instr=0, empty=1, full=0, in_ready=1.
  - Storage contents need not be cleared.
  - Reset asserted mid-operation loses all entries immediately, without waiting for a clock edge.

## Timing
- **Latency:** an entry enqueued at edge N is visible on `out_*` after edge N, so it is available to decode in cycle N+1.
  - There is no combinational bypass from in_* to out_*.
- **in_ready:** depends only on registered count, with no path from `in_valid` or `out_ready`.
- **out_* paths:** out_valid, out_pc and out_instr are combinational from registers only.
- **Full:** at count=DEPTH, in_ready=0. A simultaneous dequeue does not allow enqueue that cycle.
- **count=DEPTH−1:** in_ready=0 when FETCH_W=2. This is intentional headroom.
- **Empty:** out_valid=0 and out_ready is ignored. Count never underflows or overflows.
- **Wrap:** enqueue at tail=DEPTH−1 with two lanes writes entries 7 and 0 (DEPTH=8).
- **Flush and reset:** flush and reset in the same cycle produce the reset behaviour.
- **After flush:** in the cycle following a flush edge, out_valid=0 and in_ready=1.

## Test plan
- **Reset then single bundle:**
  - Stimulus: after reset, enqueue pc {0x0,0x4} / instr {0x20221800,0x2085_0064}.
  - Response: next cycle out_valid=11, out_pc[0]=0x0, out_pc[1]=0x4, count=2.
- **Backpressure fill:**
  - Stimulus: out_ready=0 and 4 bundles presented (pcs 0x0–0x1C).
  - Response: count=8, full=1, in_ready=0. A 5th bundle is ignored.
  - Then out_ready=1 drains the queue in order 0x0,0x4 … 0x18,0x1C.
- **Compaction:**
  - Stimulus: `in_valid=2'b10` with in_pc[1]=0x104, then `2'b11` with {0x108,0x10C}.
  - Response: out_pc sequence is 0x104, 0x108, 0x10C. With count=1, out_valid=01.
- **Simultaneous enqueue/dequeue with wrap:**
  - Stimulus: steady state with count=2, tail=7, 2-in/2-out per cycle for 6 cycles.
  - Response: count stays 2, and PCs emerge strictly in order across the 7→0 wrap.
- **Flush:**
  - Stimulus: with count=5, assert flush together with a valid enqueue and out_ready=1.
  - Response: next cycle count=0, empty=1, out_valid=00, in_ready=1. The flushed-cycle bundle never appears.
- **Async reset mid-stream:**
  - Stimulus: raise reset between clock edges with count=6.
  - Response: immediately count=0, out_valid=00, out_pc=0.
